// File: rtl/v810_pkg.sv
// v810_pkg: shared types and constants for the V810 front end.
//   ifetch_cnt_t  - 2-bit halfword count (decoder count/take)
//   hword_t       - 16-bit instruction halfword
//   V810_RESET_PC - architectural reset vector
//   cnt_min       - smaller of two counts
package v810_pkg;

  localparam logic [31:0] V810_RESET_PC = 32'hFFFF_FFF0;

  typedef logic [1:0]  ifetch_cnt_t;
  typedef logic [15:0] hword_t;

  function automatic ifetch_cnt_t cnt_min(input ifetch_cnt_t a, input ifetch_cnt_t b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/v810_ifetch_if.sv
// v810_ifetch_if: EU instruction bus between the prefetch unit and the
// instruction cache.
//   EUIA   - word-aligned fetch address   (prefetch -> cache)
//   EUIREQ - fetch request                (prefetch -> cache)
//   EUIACK - fetch acknowledge            (cache -> prefetch)
//   EUID   - fetch data, valid with EUIACK (cache -> prefetch)
interface v810_ifetch_if;
  logic [31:0] EUIA;
  logic        EUIREQ;
  logic        EUIACK;
  logic [31:0] EUID;

  modport master (output EUIA, EUIREQ, input EUIACK, EUID);
  modport slave  (input EUIA, EUIREQ, output EUIACK, EUID);
endinterface

// File: rtl/v810_ifqueue.sv
// v810_ifqueue: halfword prefetch FIFO.
//   CLK, RESn, CE        - clock, synchronous active-low reset, clock enable
//   flush                - empty the queue (wins over push and pop)
//   push, push_drop_lo   - push a 32-bit word as two halfwords, low half first;
//                          with push_drop_lo only the high half is pushed
//   push_data            - word being pushed
//   pop_n                - halfwords removed this cycle (0..2, never > count)
//   count, count_nxt     - current occupancy and occupancy after this cycle
//   peek0, peek1         - oldest and second-oldest halfword
module v810_ifqueue
  import v810_pkg::*;
#(
  parameter  int QDEPTH = 8,
  localparam int PW     = $clog2(QDEPTH),
  localparam int CW     = $clog2(QDEPTH + 1)
) (
  input  logic          CLK,
  input  logic          RESn,
  input  logic          CE,
  input  logic          flush,
  input  logic          push,
  input  logic          push_drop_lo,
  input  logic [31:0]   push_data,
  input  ifetch_cnt_t   pop_n,
  output logic [CW-1:0] count,
  output logic [CW-1:0] count_nxt,
  output hword_t        peek0,
  output hword_t        peek1
);

  localparam logic [PW:0] DEPTH = (PW + 1)'(QDEPTH);

  hword_t        mem [QDEPTH];
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_q;
  logic [CW-1:0] count_q;
  logic [1:0]    push_n;

  // Pointer advance modulo QDEPTH; QDEPTH need not be a power of two.
  function automatic logic [PW-1:0] adv(input logic [PW-1:0] p, input logic [1:0] k);
    logic [PW:0] s;
    s = {1'b0, p} + (PW + 1)'(k);
    if (s >= DEPTH) s = s - DEPTH;
    return s[PW-1:0];
  endfunction

  assign push_n    = push ? (push_drop_lo ? 2'd1 : 2'd2) : 2'd0;
  assign count_nxt = flush ? '0 : (count_q + CW'(push_n) - CW'(pop_n));

  always_ff @(posedge CLK) begin
    if (CE) begin
      if (!RESn || flush) begin
        rd_q    <= '0;
        wr_q    <= '0;
        count_q <= '0;
      end else begin
        rd_q    <= adv(rd_q, pop_n);
        wr_q    <= adv(wr_q, push_n);
        count_q <= count_nxt;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (CE && RESn && !flush && push) begin
      if (push_drop_lo) begin
        mem[wr_q] <= push_data[31:16];
      end else begin
        mem[wr_q]             <= push_data[15:0];
        mem[adv(wr_q, 2'd1)]  <= push_data[31:16];
      end
    end
  end

  assign count = count_q;
  assign peek0 = mem[rd_q];
  assign peek1 = mem[adv(rd_q, 2'd1)];

endmodule

// File: rtl/v810_ifetch.sv
// v810_ifetch: V810 instruction prefetch unit.
//   CLK, RESn, CE      - clock, synchronous active-low reset, global clock enable
//   ICMAINT            - cache maintenance; blocks new requests only
//   REDIR, REDIR_PC    - redirect strobe and target (bit0 ignored)
//   eu                 - EU instruction bus to the cache (master side)
//   DEC_PC             - PC of the head halfword
//   DEC_HW0, DEC_HW1   - two oldest queued halfwords
//   DEC_CNT            - valid halfwords presented (0..2)
//   DEC_TAKE           - halfwords consumed by the decoder this cycle
//
// Request state:
//   state | meaning
//   IDLE  | no request on the bus
//   FETCH | request on the bus, returned word goes into the queue
//   DROP  | request on the bus from before a redirect, returned word is dropped
module v810_ifetch
  import v810_pkg::*;
#(
  parameter int          QDEPTH   = 8,
  parameter logic [31:0] RESET_PC = V810_RESET_PC
) (
  input  logic         CLK,
  input  logic         RESn,
  input  logic         CE,
  input  logic         ICMAINT,
  input  logic         REDIR,
  input  logic [31:0]  REDIR_PC,
  v810_ifetch_if.master eu,
  output logic [31:0]  DEC_PC,
  output hword_t       DEC_HW0,
  output hword_t       DEC_HW1,
  output ifetch_cnt_t  DEC_CNT,
  input  ifetch_cnt_t  DEC_TAKE
);

  localparam int            CW      = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  logic [1:0]    st_q, st_d;
  logic [29:0]   fa_q, fa_d;
  logic [31:0]   ia_q, ia_d;
  logic [31:0]   pc_q, pc_d;
  logic          skip_q, skip_d;

  logic [CW-1:0] q_count;
  logic [CW-1:0] q_count_nxt;
  logic [CW-1:0] free_nxt;
  ifetch_cnt_t   cnt_vis;
  ifetch_cnt_t   take_eff;
  ifetch_cnt_t   pop_n;
  logic          accept;
  logic          hold;
  logic          push;
  logic          req_ok;

  assign cnt_vis  = (q_count >= CW'(2)) ? 2'd2 : q_count[1:0];
  assign take_eff = cnt_min(DEC_TAKE, cnt_vis);
  assign accept   = (st_q != ST_IDLE) && eu.EUIACK;
  assign hold     = (st_q != ST_IDLE) && !eu.EUIACK;
  assign push     = accept && (st_q == ST_FETCH) && !REDIR;
  assign pop_n    = REDIR ? 2'd0 : take_eff;

  // The request decision looks at the occupancy after this cycle's push and
  // pop, so a drain or an ack can be followed by a request the next cycle.
  assign free_nxt = DEPTH_C - q_count_nxt;
  assign req_ok   = !REDIR && !ICMAINT && (free_nxt >= CW'(2));

  v810_ifqueue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .CLK          (CLK),
    .RESn         (RESn),
    .CE           (CE),
    .flush        (REDIR),
    .push         (push),
    .push_drop_lo (skip_q),
    .push_data    (eu.EUID),
    .pop_n        (pop_n),
    .count        (q_count),
    .count_nxt    (q_count_nxt),
    .peek0        (DEC_HW0),
    .peek1        (DEC_HW1)
  );

  always_comb begin
    st_d   = st_q;
    fa_d   = fa_q;
    skip_d = skip_q;
    pc_d   = pc_q;

    if (REDIR) begin
      fa_d   = REDIR_PC[31:2];
      skip_d = REDIR_PC[1];
      pc_d   = REDIR_PC & 32'hFFFF_FFFE;
    end else begin
      pc_d = pc_q + {29'd0, take_eff, 1'b0};
      if (push) begin
        fa_d   = fa_q + 30'd1;
        skip_d = 1'b0;
      end
    end

    // An unacked request keeps EUIREQ/EUIA frozen; a redirect only marks it
    // for dropping because the cache may already be filling that line.
    if (hold) begin
      st_d = REDIR ? ST_DROP : st_q;
    end else begin
      st_d = req_ok ? ST_FETCH : ST_IDLE;
    end

    ia_d = hold ? ia_q : {fa_d, 2'b00};
  end

  always_ff @(posedge CLK) begin
    if (CE) begin
      if (!RESn) begin
        st_q   <= ST_IDLE;
        fa_q   <= RESET_PC[31:2];
        ia_q   <= {RESET_PC[31:2], 2'b00};
        skip_q <= RESET_PC[1];
        pc_q   <= RESET_PC;
      end else begin
        st_q   <= st_d;
        fa_q   <= fa_d;
        ia_q   <= ia_d;
        skip_q <= skip_d;
        pc_q   <= pc_d;
      end
    end
  end

  assign eu.EUIREQ = (st_q != ST_IDLE);
  assign eu.EUIA   = ia_q;
  assign DEC_PC    = pc_q;
  assign DEC_CNT   = cnt_vis;

endmodule

// File: tb/tb_v810_ifetch.sv
module tb_v810_ifetch;
  import v810_pkg::*;

  localparam int          QD  = 8;
  localparam logic [31:0] RPC = 32'hFFFF_FFF0;

  logic        CLK = 1'b0;
  logic        RESn;
  logic        CE;
  logic        ICMAINT;
  logic        REDIR;
  logic [31:0] REDIR_PC;
  logic [31:0] DEC_PC;
  logic [15:0] DEC_HW0;
  logic [15:0] DEC_HW1;
  logic [1:0]  DEC_CNT;
  logic [1:0]  DEC_TAKE;

  int errors = 0;
  int checks = 0;

  v810_ifetch_if eu();

  // Cache model: word data is a fixed function of its address.
  assign eu.EUID = eu.EUIACK ? (32'hA000_B000 + eu.EUIA) : 32'h5A5A_5A5A;

  v810_ifetch #(.QDEPTH(QD), .RESET_PC(RPC)) dut (
    .CLK      (CLK),
    .RESn     (RESn),
    .CE       (CE),
    .ICMAINT  (ICMAINT),
    .REDIR    (REDIR),
    .REDIR_PC (REDIR_PC),
    .eu       (eu),
    .DEC_PC   (DEC_PC),
    .DEC_HW0  (DEC_HW0),
    .DEC_HW1  (DEC_HW1),
    .DEC_CNT  (DEC_CNT),
    .DEC_TAKE (DEC_TAKE)
  );

  always #5 CLK = ~CLK;

  // Reference model: the decoder sees an in-order stream of halfwords.
  logic [15:0] mq[$];
  logic [31:0] m_pc, m_fa, m_ia;
  logic        m_req, m_disc, m_skip;
  logic [15:0] drain_exp [4] = '{16'hE000, 16'hA000, 16'hE004, 16'hA000};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [31:0] d;
    int vis, te;
    if (!CE) return;
    if (!RESn) begin
      mq.delete();
      m_pc = RPC; m_fa = RPC & ~32'h3; m_ia = m_fa;
      m_skip = RPC[1]; m_req = 1'b0; m_disc = 1'b0;
      return;
    end
    d   = 32'hA000_B000 + m_ia;
    vis = (mq.size() > 2) ? 2 : mq.size();
    te  = (int'(DEC_TAKE) < vis) ? int'(DEC_TAKE) : vis;
    if (REDIR) begin
      mq.delete();
      m_pc   = REDIR_PC & ~32'h1;
      m_fa   = REDIR_PC & ~32'h3;
      m_skip = REDIR_PC[1];
      if (m_req && !eu.EUIACK) m_disc = 1'b1;
      else begin m_req = 1'b0; m_disc = 1'b0; m_ia = m_fa; end
      return;
    end
    for (int i = 0; i < te; i++) void'(mq.pop_front());
    m_pc = m_pc + 32'(2 * te);
    if (m_req && !eu.EUIACK) return;
    if (m_req) begin
      if (!m_disc) begin
        if (!m_skip) mq.push_back(d[15:0]);
        mq.push_back(d[31:16]);
        m_skip = 1'b0;
        m_fa   = m_fa + 32'd4;
      end
      m_disc = 1'b0;
    end
    m_req = !ICMAINT && ((QD - mq.size()) >= 2);
    m_ia  = m_fa;
  endtask

  task automatic compare_all();
    int n;
    n = mq.size();
    chk("euireq", 32'(eu.EUIREQ), 32'(m_req));
    chk("euia", eu.EUIA, m_ia);
    chk("dec_pc", DEC_PC, m_pc);
    chk("dec_cnt", 32'(DEC_CNT), 32'((n > 2) ? 2 : n));
    if (n >= 1) chk("dec_hw0", 32'(DEC_HW0), 32'(mq[0]));
    if (n >= 2) chk("dec_hw1", 32'(DEC_HW1), 32'(mq[1]));
  endtask

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    RESn = 1'b0; CE = 1'b1; ICMAINT = 1'b0; REDIR = 1'b0; REDIR_PC = '0;
    DEC_TAKE = 2'd0; eu.EUIACK = 1'b0;
    m_req = 1'b0; m_disc = 1'b0; m_skip = 1'b0; m_pc = '0; m_fa = '0; m_ia = '0;

    // Reset
    step(); step();
    chk("rst_req", 32'(eu.EUIREQ), 32'd0);
    chk("rst_cnt", 32'(DEC_CNT), 32'd0);
    chk("rst_pc", DEC_PC, 32'hFFFF_FFF0);
    chk("rst_euia", eu.EUIA, 32'hFFFF_FFF0);

    // Always-ack cache, no consumption: fill up
    RESn = 1'b1; eu.EUIACK = 1'b1;
    step();
    chk("first_req", 32'(eu.EUIREQ), 32'd1);
    chk("first_euia", eu.EUIA, 32'hFFFF_FFF0);
    step();
    chk("second_euia", eu.EUIA, 32'hFFFF_FFF4);
    chk("first_cnt", 32'(DEC_CNT), 32'd2);
    chk("first_hw0", 32'(DEC_HW0), 32'h0000_AFF0);
    chk("first_pc", DEC_PC, 32'hFFFF_FFF0);
    repeat (8) step();
    chk("full_req", 32'(eu.EUIREQ), 32'd0);
    chk("full_euia_wrap", eu.EUIA, 32'h0000_0000);
    DEC_TAKE = 2'd2;
    step();
    DEC_TAKE = 2'd0;
    chk("take_req", 32'(eu.EUIREQ), 32'd1);
    chk("take_pc", DEC_PC, 32'hFFFF_FFF4);
    step();

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      CE       = ($urandom_range(9) != 0);
      RESn     = ($urandom_range(299) != 0);
      REDIR    = ($urandom_range(15) == 0);
      REDIR_PC = ($urandom_range(3) == 0) ? (32'hFFFF_FFF8 | $urandom_range(7)) : $urandom;
      ICMAINT  = ($urandom_range(7) == 0);
      eu.EUIACK = 1'($urandom_range(1));
      DEC_TAKE = 2'($urandom_range(2));
      step();
    end

    // Quiesce: drain, ack anything outstanding, no new requests
    CE = 1'b1; RESn = 1'b1; REDIR = 1'b0; ICMAINT = 1'b1; eu.EUIACK = 1'b1; DEC_TAKE = 2'd2;
    repeat (10) step();

    // Redirect while a request is held unacked
    ICMAINT = 1'b0; DEC_TAKE = 2'd0; eu.EUIACK = 1'b0;
    REDIR = 1'b1; REDIR_PC = 32'h0000_0100;
    step();
    REDIR = 1'b0;
    step();
    chk("hold_req", 32'(eu.EUIREQ), 32'd1);
    chk("hold_euia0", eu.EUIA, 32'h0000_0100);
    step();
    chk("hold_euia1", eu.EUIA, 32'h0000_0100);
    REDIR = 1'b1; REDIR_PC = 32'h0000_1002;
    step();
    REDIR = 1'b0;
    chk("hold_euia2", eu.EUIA, 32'h0000_0100);
    chk("redir_pc", DEC_PC, 32'h0000_1002);
    chk("redir_cnt", 32'(DEC_CNT), 32'd0);
    step();
    chk("hold_euia3", eu.EUIA, 32'h0000_0100);
    eu.EUIACK = 1'b1;
    step();
    chk("disc_next_euia", eu.EUIA, 32'h0000_1000);
    chk("disc_cnt", 32'(DEC_CNT), 32'd0);
    step();
    chk("skip_cnt", 32'(DEC_CNT), 32'd1);
    chk("skip_hw0", 32'(DEC_HW0), 32'h0000_A000);
    chk("skip_pc", DEC_PC, 32'h0000_1002);
    step();

    // Redirect coinciding with ack and TAKE=2
    REDIR = 1'b1; REDIR_PC = 32'h0000_2000; DEC_TAKE = 2'd2;
    step();
    REDIR = 1'b0; DEC_TAKE = 2'd0; eu.EUIACK = 1'b0;
    chk("same_cnt", 32'(DEC_CNT), 32'd0);
    chk("same_euia", eu.EUIA, 32'h0000_2000);
    step();
    chk("same_cnt2", 32'(DEC_CNT), 32'd0);

    // Cache maintenance with four halfwords queued
    REDIR = 1'b1; REDIR_PC = 32'h0000_3000;
    step();
    REDIR = 1'b0; eu.EUIACK = 1'b1;
    step(); step();
    ICMAINT = 1'b1;
    step();
    chk("icm_req0", 32'(eu.EUIREQ), 32'd0);
    chk("icm_cnt", 32'(DEC_CNT), 32'd2);
    for (int i = 0; i < 128; i++) begin
      eu.EUIACK = 1'($urandom_range(1));
      DEC_TAKE = (i >= 100 && i < 104) ? 2'd1 : 2'd0;
      if (i >= 100 && i < 104) chk("drain_hw0", 32'(DEC_HW0), 32'(drain_exp[i-100]));
      step();
      chk("icm_req", 32'(eu.EUIREQ), 32'd0);
    end
    chk("icm_empty", 32'(DEC_CNT), 32'd0);
    ICMAINT = 1'b0; DEC_TAKE = 2'd0; eu.EUIACK = 1'b0;
    step();
    chk("icm_resume", 32'(eu.EUIREQ), 32'd1);
    chk("icm_resume_euia", eu.EUIA, 32'h0000_3008);

    // Address and PC wrap
    REDIR = 1'b1; REDIR_PC = 32'hFFFF_FFFC; eu.EUIACK = 1'b1;
    step();
    REDIR = 1'b0; eu.EUIACK = 1'b0;
    step();
    chk("wrap_euia0", eu.EUIA, 32'hFFFF_FFFC);
    eu.EUIACK = 1'b1;
    step();
    eu.EUIACK = 1'b0;
    chk("wrap_euia1", eu.EUIA, 32'h0000_0000);
    chk("wrap_pc0", DEC_PC, 32'hFFFF_FFFC);
    DEC_TAKE = 2'd1;
    step();
    chk("wrap_pc1", DEC_PC, 32'hFFFF_FFFE);
    step();
    chk("wrap_pc2", DEC_PC, 32'h0000_0000);
    DEC_TAKE = 2'd0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/v810_ifetch.md
Name: v810_ifetch

Overview:
Instruction prefetch unit between the V810 decoder and the instruction cache. Drives the cache's EU instruction bus (EUIA/EUIREQ/EUIACK/EUID) with sequential word addresses. Buffers returned words as halfwords in a prefetch queue and presents the two oldest halfwords, with their PC, to the decoder. Branch/exception redirects flush the queue and discard any in-flight fetch.

Parameters:
QDEPTH, 8, prefetch queue capacity in halfwords (even, >=4)
RESET_PC, 32'hFFFF_FFF0, fetch and decode PC after reset

Ports:
CLK  in  1  clock
RESn  in  1  reset, synchronous, active-low
CE  in  1  global clock enable; all state updates gated by it
ICMAINT  in  1  cache maintenance active; no new requests
REDIR  in  1  redirect strobe (branch/trap/reti)
REDIR_PC  in  32  redirect target; bit0 ignored
EUIA  out  32  fetch address, always word-aligned
EUIREQ  out  1  fetch request
EUIACK  in  1  fetch acknowledge
EUID  in  32  fetch data; valid when EUIACK=1
DEC_PC  out  32  PC of head halfword (bit0=0)
DEC_HW0  out  16  head halfword
DEC_HW1  out  16  second halfword
DEC_CNT  out  2  valid halfwords presented: 0, 1 or 2 (saturates at 2)
DEC_TAKE  in  2  halfwords consumed this cycle (0..2)

Behaviour:
- Reset (RESn=0 on a CE cycle): queue empty, DEC_CNT=0, EUIREQ=0, fetch PC=RESET_PC&~3, DEC_PC=RESET_PC, skip=RESET_PC[1], discard=0. This is the reset value of every output.
- State: fetch address FA[31:2], queue (rd/wr pointers plus count), busy flag, discard flag, skip flag, DEC_PC.
- Request:
  - Assert EUIREQ when idle (busy=0), ICMAINT=0, REDIR=0, and free slots >= 2 (free slots exclude nothing outstanding; only one request can be in flight).
  - Once asserted, EUIREQ and EUIA stay stable until EUIACK is seen on a CE cycle, regardless of ICMAINT or REDIR. The cache uses EUIA combinationally during a fill.
- Acceptance: CE & EUIREQ & EUIACK.
  - FA <= FA+1, wrapping 0xFFFFFFFC -> 0x00000000.
  - If discard=0, push EUID[15:0] then EUID[31:16] (little-endian).
  - If skip=1, drop [15:0], push only [31:16], and clear skip.
- Zero-wait path: an acceptance in cycle N makes the data visible on DEC_* in N+1. The next request may be asserted in N+1.
- Consumption:
  - Effective take = min(DEC_TAKE, DEC_CNT).
  - Pop that many halfwords; DEC_PC += 2*take (mod 2^32).
  - Pop and push in the same cycle are both applied; count = count + pushed - taken.
- Redirect (CE & REDIR):
  - Queue flushed; DEC_CNT=0 next cycle; DEC_PC=REDIR_PC&~1.
  - FA=REDIR_PC[31:2]; skip=REDIR_PC[1].
  - If a request is outstanding and not acked this cycle: discard=1 until its ack, then discard clears. The ack is dropped and FA is not incremented.
  - If the ack lands in the same cycle as REDIR: the data is dropped and FA takes the target.
  - REDIR beats DEC_TAKE and push in the same cycle.
  - The new fetch issues at the earliest in the cycle after REDIR (or after the discarded ack).
- ICMAINT: blocks only new requests. The queue keeps draining.
- Full: if free slots < 2, no request. A queue holding QDEPTH-1 halfwords does not fetch.
- CE=0: no state changes; outputs hold.
- Reset mid-fetch: request dropped immediately (EUIREQ=0 the next cycle). The cache's own reset clears its fill.

Decomposition:
- Add to v810_pkg: ifetch_cnt_t (2-bit count type) and localparam V810_RESET_PC = 32'hFFFF_FFF0 (used as the RESET_PC default).
- One sub-module, v810_ifqueue: a halfword FIFO with 0/1/2-wide push (with low-half drop), 0/1/2-wide pop, flush, count, and two-entry peek.
- Request/redirect control stays in v810_ifetch.

Test Plan:
- Reset with RESET_PC=FFFFFFF0, cache always acks with EUID=A000_B000+addr: EUIA=FFFFFFF0, then FFFFFFF4. DEC_HW0=...F0 low half, DEC_PC=FFFFFFF0, DEC_CNT=2 one cycle after the first ack.
- Hold DEC_TAKE=0: fetches stop with count >= QDEPTH-1 (8 -> count 8, EUIREQ=0). TAKE=2 for one cycle -> EUIREQ reasserts next cycle, DEC_PC advances by 4.
- Redirect to 0x0000_1002 while a request to 0x100 is held unacked for 3 cycles: EUIA stays 0x100 until ack. The ack data never appears. The next EUIA is 0x1000, and DEC_HW0 = the high half of word 0x1000 with DEC_PC=0x1002.
- Redirect on the same cycle as ack plus DEC_TAKE=2: queue empty next cycle, EUIA=target next cycle, no stale halfwords.
- ICMAINT=1 for 128 cycles with 4 halfwords queued: EUIREQ=0 throughout. Decoder drains 4 halfwords correctly. Fetch resumes the cycle after ICMAINT falls.
- Fetch at 0xFFFFFFFC acked: next EUIA=0x00000000. DEC_PC wraps FFFFFFFE -> 00000000 across TAKE.
